core_bus_arbiter: RTL and testbench

- Shares one downstream memory port among N requesters: instruction fetch, data access, and a future page-table walker.
- Sits between the core's request/response ports and the memory/cache bus.
- Grants one requester at a time and latches its request fields.
- Holds the grant until the downstream data_ok, then routes that response back to the owner only.

---
 rtl/core_bus_arbiter_if.sv | 39 +++
 rtl/core_bus_arbiter.sv | 104 ++++++++++
 tb/tb_core_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_arbiter_if.sv
// Bundles the requester-side and memory-side signals of core_bus_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface core_bus_arbiter_if #(
    parameter int N  = 3,
    parameter int AW = 64,
    parameter int DW = 64
);
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*3-1:0]  req_size;
    logic [N*8-1:0]  req_strobe;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    resp_addr_ok;
    logic [N-1:0]    resp_data_ok;
    logic [DW-1:0]   resp_data;

    logic            mreq_valid;
    logic [AW-1:0]   mreq_addr;
    logic [2:0]      mreq_size;
    logic [7:0]      mreq_strobe;
    logic [DW-1:0]   mreq_data;
    logic            mresp_addr_ok;
    logic            mresp_data_ok;
    logic [DW-1:0]   mresp_data;

    modport slave (
        input  req_valid, req_addr, req_size, req_strobe, req_data,
        output resp_addr_ok, resp_data_ok, resp_data,
        output mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        input  mresp_addr_ok, mresp_data_ok, mresp_data
    );

    modport master (
        output req_valid, req_addr, req_size, req_strobe, req_data,
        input  resp_addr_ok, resp_data_ok, resp_data,
        input  mreq_valid, mreq_addr, mreq_size, mreq_strobe, mreq_data,
        output mresp_addr_ok, mresp_data_ok, mresp_data
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Shares one memory port among N requesters, one transaction at a time.
// Define CORE_BUS_ARB_RR_EN for round-robin arbitration (default: fixed priority, index 0 highest).
module core_bus_arbiter #(
    parameter int N  = 3,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                clk,
    input  logic                reset,
    core_bus_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t          state_q;
    logic [OW-1:0]   owner_q;
    logic [AW-1:0]   addr_q;
    logic [2:0]      size_q;
    logic [7:0]      strobe_q;
    logic [DW-1:0]   data_q;
    logic [OW-1:0]   win_d;
    logic            in_req;
`ifdef CORE_BUS_ARB_RR_EN
    logic [OW-1:0]   rr_ptr_q;
`endif

    assign in_req = (state_q == REQ);
    assign busy   = in_req;

    always_comb begin
        win_d = '0;
`ifdef CORE_BUS_ARB_RR_EN
        begin
            logic found;
            int   idx;
            found = 1'b0;
            idx   = 0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(rr_ptr_q) + k) % N;
                if (!found && bus.req_valid[idx]) begin
                    win_d = OW'(idx);
                    found = 1'b1;
                end
            end
        end
`else
        // Scan downward so the lowest valid index is the last write and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) win_d = OW'(i);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
`ifdef CORE_BUS_ARB_RR_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner_q  <= win_d;
                        addr_q   <= bus.req_addr[int'(win_d)*AW +: AW];
                        size_q   <= bus.req_size[int'(win_d)*3 +: 3];
                        strobe_q <= bus.req_strobe[int'(win_d)*8 +: 8];
                        data_q   <= bus.req_data[int'(win_d)*DW +: DW];
                        state_q  <= REQ;
                    end
                end
                REQ: begin
                    if (bus.mresp_data_ok) begin
                        state_q <= IDLE;
`ifdef CORE_BUS_ARB_RR_EN
                        rr_ptr_q <= (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Downstream sees only the latched fields, and nothing at all outside REQ.
    assign bus.mreq_valid  = in_req;
    assign bus.mreq_addr   = in_req ? addr_q   : '0;
    assign bus.mreq_size   = in_req ? size_q   : '0;
    assign bus.mreq_strobe = in_req ? strobe_q : '0;
    assign bus.mreq_data   = in_req ? data_q   : '0;
    assign bus.resp_data   = (in_req && bus.mresp_data_ok) ? bus.mresp_data : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_resp
        assign bus.resp_addr_ok[gi] = in_req && (owner_q == OW'(gi)) && bus.mresp_addr_ok;
        assign bus.resp_data_ok[gi] = in_req && (owner_q == OW'(gi)) && bus.mresp_data_ok;
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Randomized and directed bench for core_bus_arbiter against a transaction-level reference model.
module tb_core_bus_arbiter;
    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk;
    logic rst;
    logic busy;
    int   n_checks;
    int   n_pass;

    // Reference model: who owns the port and what was captured at grant.
    bit          m_busy;
    int          m_owner;
    int          m_rr;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_data;

    core_bus_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

    core_bus_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick(input logic [N-1:0] v);
`ifdef CORE_BUS_ARB_RR_EN
        for (int k = 0; k < N; k++) if (v[(m_rr + k) % N]) return (m_rr + k) % N;
`else
        for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] s, input logic [2:0] sz);
        bus.req_addr[i*64 +: 64] = a;
        bus.req_data[i*64 +: 64] = d;
        bus.req_strobe[i*8 +: 8] = s;
        bus.req_size[i*3 +: 3]   = sz;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++)
            set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom), 3'($urandom));
    endtask

    // Compare every output against the model with inputs already applied.
    task automatic settle_check();
        logic [2:0] exp_aok;
        logic [2:0] exp_dok;
        #1;
        exp_aok = (m_busy && bus.mresp_addr_ok) ? 3'(1 << m_owner) : 3'b0;
        exp_dok = (m_busy && bus.mresp_data_ok) ? 3'(1 << m_owner) : 3'b0;
        chk("busy",         busy,              64'(m_busy));
        chk("mreq_valid",   bus.mreq_valid,    64'(m_busy));
        chk("mreq_addr",    bus.mreq_addr,     m_busy ? m_addr : 64'h0);
        chk("mreq_size",    bus.mreq_size,     m_busy ? 64'(m_size) : 64'h0);
        chk("mreq_strobe",  bus.mreq_strobe,   m_busy ? 64'(m_strobe) : 64'h0);
        chk("mreq_data",    bus.mreq_data,     m_busy ? m_data : 64'h0);
        chk("resp_addr_ok", bus.resp_addr_ok,  64'(exp_aok));
        chk("resp_data_ok", bus.resp_data_ok,  64'(exp_dok));
        chk("resp_data",    bus.resp_data,     (exp_dok != 0) ? bus.mresp_data : 64'h0);
        chk("onehot0",      64'($onehot0(bus.resp_data_ok)), 64'd1);
        chk("dok_wo_mem",   64'((bus.resp_data_ok != 0) && !bus.mresp_data_ok), 64'd0);
    endtask

    // Advance one clock and apply the transaction rules to the model.
    task automatic clk_edge();
        @(posedge clk);
        #1;
        if (rst) begin
            m_busy = 0;
            m_rr   = 0;
        end else if (m_busy) begin
            if (bus.mresp_data_ok) begin
                m_busy = 0;
                m_rr   = (m_owner + 1) % N;
                $display("txn owner=%0d addr=%h strobe=%h rdata=%h",
                         m_owner, m_addr, m_strobe, bus.mresp_data);
            end
        end else if (bus.req_valid != 0) begin
            m_owner  = pick(bus.req_valid);
            m_addr   = bus.req_addr[m_owner*64 +: 64];
            m_size   = bus.req_size[m_owner*3 +: 3];
            m_strobe = bus.req_strobe[m_owner*8 +: 8];
            m_data   = bus.req_data[m_owner*64 +: 64];
            m_busy   = 1;
        end
    endtask

    task automatic drive(input logic [2:0] rv, input bit aok, input bit dok, input logic [63:0] md);
        bus.req_valid     = rv;
        bus.mresp_addr_ok = aok;
        bus.mresp_data_ok = dok;
        bus.mresp_data    = md;
        settle_check();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 0, 0, 64'h0);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_mreq_valid", bus.mreq_valid, 64'd0);
        rst = 1'b0;
    endtask

    // One complete transaction of a held request set; returns completion pattern.
    task automatic one_txn(input logic [2:0] rv, output logic [2:0] done);
        drive(rv, 0, 0, 64'h0);
        clk_edge();
        drive(rv, 1, 1, 64'h1234);
        done = bus.resp_data_ok;
        clk_edge();
    endtask

    logic [2:0] done;
    logic [2:0] exp_grant [3];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_busy   = 0;
        m_owner  = 0;
        m_rr     = 0;
        rst      = 1'b1;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_size = '0;
        bus.req_strobe = '0; bus.req_data = '0;
        bus.mresp_addr_ok = 0; bus.mresp_data_ok = 0; bus.mresp_data = '0;
        clk_edge();
        do_reset();
        clk_edge();

        // Single fetch: grant at cycle 1, completion at cycle 3.
        set_req(2, 64'h8000_0000, 64'h0, 8'h00, 3'd2);
        drive(3'b100, 0, 0, 64'h0);
        chk("fetch_c0_mv", bus.mreq_valid, 64'd0);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        chk("fetch_c1_mv", bus.mreq_valid, 64'd1);
        chk("fetch_c1_addr", bus.mreq_addr, 64'h8000_0000);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        clk_edge();
        drive(3'b000, 1, 1, 64'h13);
        chk("fetch_c3_dok", bus.resp_data_ok, 64'b100);
        chk("fetch_c3_rdata", bus.resp_data, 64'h13);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        chk("fetch_c4_busy", busy, 64'd0);
        clk_edge();

        // Contention on 0 and 2 for three transactions.
        do_reset();
        clk_edge();
`ifdef CORE_BUS_ARB_RR_EN
        exp_grant = '{3'b001, 3'b100, 3'b001};
`else
        exp_grant = '{3'b001, 3'b001, 3'b001};
`endif
        for (int t = 0; t < 3; t++) begin
            one_txn(3'b101, done);
            chk("contention_grant", done, exp_grant[t]);
        end

        // Owner 1 completes (round-robin pointer wraps to 2), then 0 and 1 contend.
        one_txn(3'b010, done);
        chk("wrap_first", done, 64'b010);
        one_txn(3'b011, done);
        chk("wrap_grant", done, 64'b001);

        // Latched fields survive changes to the live request.
        set_req(0, 64'h40, 64'hDEAD_BEEF, 8'hFF, 3'd3);
        drive(3'b001, 0, 0, 64'h0);
        clk_edge();
        set_req(0, 64'h0, 64'h0, 8'h00, 3'd0);
        drive(3'b001, 0, 0, 64'h0);
        chk("latch_data", bus.mreq_data, 64'hDEAD_BEEF);
        chk("latch_strobe", bus.mreq_strobe, 64'hFF);
        clk_edge();
        drive(3'b000, 1, 1, 64'h0);
        chk("latch_data_end", bus.mreq_data, 64'hDEAD_BEEF);
        clk_edge();

        // Split handshake: addr_ok at cycle 2, data_ok at cycle 6.
        drive(3'b001, 0, 0, 64'h0);
        clk_edge();
        for (int c = 1; c <= 6; c++) begin
            drive(3'b000, c == 2, c == 6, 64'h55);
            chk("split_mv", bus.mreq_valid, 64'd1);
            chk("split_aok", bus.resp_addr_ok, (c == 2) ? 64'b001 : 64'b000);
            chk("split_dok", bus.resp_data_ok, (c == 6) ? 64'b001 : 64'b000);
            clk_edge();
        end

        // Reset mid-REQ abandons the transaction.
        drive(3'b001, 0, 0, 64'h0);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        clk_edge();
        drive(3'b000, 0, 0, 64'h0);
        clk_edge();
        rst = 1'b1;
        drive(3'b000, 0, 0, 64'h0);
        clk_edge();
        rst = 1'b0;
        drive(3'b000, 1, 1, 64'h77);
        chk("rstmid_mv", bus.mreq_valid, 64'd0);
        chk("rstmid_busy", busy, 64'd0);
        chk("rstmid_dok", bus.resp_data_ok, 64'd0);
        clk_edge();
        one_txn(3'b100, done);
        chk("rstmid_fresh", done, 64'b100);

        // Owner 2 drops valid; it still completes once, then requester 1 is served.
        drive(3'b100, 0, 0, 64'h0);
        clk_edge();
        drive(3'b010, 0, 0, 64'h0);
        clk_edge();
        drive(3'b010, 0, 1, 64'h9);
        chk("drop_dok", bus.resp_data_ok, 64'b100);
        clk_edge();
        drive(3'b010, 0, 1, 64'h9);
        chk("drop_once", bus.resp_data_ok, 64'b000);
        clk_edge();
        drive(3'b000, 0, 1, 64'h9);
        chk("drop_next", bus.resp_data_ok, 64'b010);
        clk_edge();

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst = ($urandom_range(0, 63) == 0);
            rand_fields();
            drive(($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  {$urandom, $urandom});
            clk_edge();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
